riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values 8, 16, 32 or 64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1  input  XLEN  first operand (dividend/multiplicand).
REQ-007 rs2  input  XLEN  second operand (divisor/multiplier).
REQ-008 kill  input  1  abort of the in-flight operation (pipeline flush).
REQ-009 busy  output  1  high while an operation is iterating.
REQ-010 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-011 result  output  XLEN  registered result; held until the next accepted start.

Function
REQ-012 FSM states: IDLE, CALC, DONE.
- IDLE/DONE + start=1 -> CALC, or -> DONE for a fast-path case.
- CALC with iteration count = XLEN-1 -> DONE.
- DONE + start=0 -> IDLE.
REQ-013 On the accepting edge, op, rs1 and rs2 are latched; input changes during CALC have no effect.
REQ-014 Normal latency: start sampled at edge 0 -> busy=1 in cycles 1..XLEN, done=1 in cycle XLEN+1, busy=0 in that cycle.
REQ-015 start with busy=1 is ignored; start in the DONE cycle is accepted (back-to-back, no idle bubble).
REQ-016 Multiply is radix-2 shift-add over XLEN iterations on operand magnitudes, producing a 2*XLEN product.
- Sign is applied at the end: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned magnitude path.
- MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
REQ-017 Divide is restoring radix-2 over XLEN iterations on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-018 Divide by zero (rs2=0, ops 100-111) takes the fast path, skipping CALC, with done in cycle 1.
- Quotient = all ones.
- Remainder = rs1.
REQ-019 Signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1) takes the fast path with done in cycle 1.
- Quotient = rs1.
- Remainder = 0.
REQ-020 kill=1 in any state -> IDLE at the next edge; no done is issued and result is unchanged.
- kill has priority over start in the same cycle.
REQ-021 done is never asserted in two consecutive cycles for one operation; exactly one done per accepted, unkilled start.
REQ-022 All arithmetic is internal XLEN+1 or 2*XLEN wide; no truncation other than the final result select.

Reset
REQ-023 rst=0 forces, asynchronously:
- state = IDLE, busy = 0, done = 0, result = 0, iteration counter = 0.
REQ-024 Reset during CALC discards the operation; no done follows deassertion.
REQ-025 After rst deasserts, the first start is accepted at the first rising edge with rst=1.

Verification (XLEN=32)
REQ-026 MUL rs1=7, rs2=0xFFFFFFFD, start at edge 0 -> busy cycles 1..32; done=1 in cycle 33 with result=0xFFFFFFEB.
REQ-027 Operands rs1=rs2=0xFFFFFFFF:
- MULHU -> 0xFFFFFFFE.
- MULH -> 0x00000000.
- MULHSU -> 0xFFFFFFFF.
REQ-028 rs1=0xFFFFFFF9 (-7), rs2=2:
- DIV -> 0xFFFFFFFD.
- REM -> 0xFFFFFFFF.
- DIVU -> 0x7FFFFFFC.
- REMU -> 0x00000001.
REQ-029 Fast paths:
- DIVU 5/0 -> 0xFFFFFFFF, done in cycle 1.
- REMU 5/0 -> 0x00000005.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done in cycle 1.
- REM 0x80000000/0xFFFFFFFF -> 0.
REQ-030 Start DIV, kill=1 in cycle 10 -> state IDLE and busy=0 in cycle 11, no done, result unchanged; a new start in cycle 11 completes normally.
REQ-031 rst=0 pulsed mid-CALC -> busy=0, done=0, result=0 immediately; back-to-back starts in DONE cycles yield one done per operation.

Source files
------------

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with single-cycle fast paths for divide-by-zero and overflow.
module riscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            busy_q, done_q, neg_q;
  logic [XLEN-1:0] result_q, hi_q, lo_q, b_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;

  // Operand decode on the request inputs (used only on the accepting edge)
  logic            s1_sgn, s2_sgn, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    s1_sgn   = rs1[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    s2_sgn   = rs2[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    mag1     = s1_sgn ? -rs1 : rs1;
    mag2     = s2_sgn ? -rs2 : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op[1] ? rs1 : '1;
    else          fast_res = op[1] ? '0 : rs1;
  end

  // One iteration step; {hi,lo} is the product / {remainder,quotient} pair
  logic [XLEN:0]   sum, shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] hi_d, lo_d;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (op_q[2]) begin
      shifted = {hi_q, lo_q[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, b_q};
      if (!diff[XLEN+1]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shifted[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select, taken from the final iteration's output
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_res;

  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_d : lo_d;
    rem_s  = neg_q ? -hi_d : hi_d;
    if (op_q[2])               calc_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) calc_res = prod_s[XLEN-1:0];
    else                       calc_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              op_q  <= op;
              hi_q  <= '0;
              lo_q  <= mag1;
              b_q   <= mag2;
              // Remainder follows the dividend; everything else follows the operand sign mix
              neg_q <= (op[2] && op[1]) ? s1_sgn : (s1_sgn ^ s2_sgn);
              cnt_q <= '0;
              if (fast) begin
                state_q  <= S_DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= fast_res;
              end else begin
                state_q <= S_CALC;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_CALC: begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= calc_res;
              cnt_q    <= '0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (XLEN=32): directed cases, kill/reset behaviour,
// back-to-back issue and randomized operations against an arithmetic reference model.
module tb_riscv_muldiv;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference semantics of the RV32M instructions using wide native arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0]        up;
    logic [31:0]        r;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (o)
      3'd0: r = a * b;
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues an op in the current cycle and follows it to its done cycle
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    int busy_cyc;
    bit got;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom; start = 1'b0;
    cyc = 1; busy_cyc = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cyc++;
        start = (cyc < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_got_done"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat - 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp));
  endtask

  task automatic idle_check(input string tag, input logic [31:0] held);
    tick();
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_result_held"}, 64'(result), 64'(held));
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  o;
    logic [31:0] a, b, e;
    int          dcount;

    #1 rst = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    #19 rst = 1'b1;

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    idle_check("mul_7_m3", 32'hFFFF_FFEB);
    run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    idle_check("mulhu_m1", 32'hFFFF_FFFE);
    run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    idle_check("mulh_m1", 32'h0);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    idle_check("mulhsu_m1", 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    idle_check("div_m7_2", 32'hFFFF_FFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    idle_check("rem_m7_2", 32'hFFFF_FFFF);
    run_op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    idle_check("divu_m7_2", 32'h7FFF_FFFC);
    run_op("remu_m7_2", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33);
    idle_check("remu_m7_2", 32'h0000_0001);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    idle_check("divu_by0", 32'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    idle_check("remu_by0", 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    idle_check("div_ovf", 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    idle_check("rem_ovf", 32'h0);

    // Kill in cycle 10 of a divide, then restart in cycle 11
    prev = result;
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) dcount++;
      tick();
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_no_done_before", 64'(dcount), 64'd0);
    check("kill_state_idle", 64'(dbg_state), 64'd0);
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_done", 64'(done), 64'd0);
    check("kill_result_held", 64'(result), 64'(prev));
    run_op("after_kill", 3'd5, 32'd1000, 32'd7, 32'd142, 33);
    idle_check("after_kill", 32'd142);

    // Kill wins over a simultaneous start
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill_prio_busy", 64'(busy), 64'd0);
    check("kill_prio_state", 64'(dbg_state), 64'd0);
    tick();
    check("kill_prio_no_done", 64'(done), 64'd0);

    // Asynchronous reset in the middle of a multiply
    op = 3'd0; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    #3 rst = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) dcount++;
    end
    check("midrst_no_done", 64'(dcount), 64'd0);

    // Back-to-back issue from DONE cycles
    run_op("b2b_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("b2b_div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("b2b_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    idle_check("b2b_remu", 32'd2);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      e = ref_res(o, a, b);
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, e, ref_lat(o, a, b));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i), e);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
